blob_tracker: RTL and testbench

BLOB_TRACKER -- requirements
Module: blob_tracker

---
 rtl/tracker_pkg.sv | 31 +++
 rtl/coord_clamp.sv | 23 ++
 rtl/blob_tracker.sv | 225 ++++++++++++++++++++++
 tb/tb_blob_tracker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared types and constants for the blob tracker: FSM states, the
// "no object" coordinate marker, default frame size and a saturating helper.
package tracker_pkg;

    typedef logic [10:0]        coord_t;
    typedef logic signed [11:0] vel_t;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        COAST   = 2'd3
    } track_state_t;

    localparam coord_t NOT_FOUND      = 11'd2023;
    localparam int     DEFAULT_WIDTH  = 640;
    localparam int     DEFAULT_HEIGHT = 480;

    // Coordinate plus velocity, saturated to the top of the signed 12-bit
    // range so a large forward jump cannot wrap negative before clamping.
    // The lower end cannot underflow because the coordinate is never negative.
    function automatic vel_t sat_add(input coord_t base, input vel_t step);
        logic signed [12:0] sum;
        sum = $signed({2'b00, base}) + $signed({step[11], step});
        if (sum > 13'sd2047) begin
            return 12'sd2047;
        end
        return sum[11:0];
    endfunction

endpackage

// File: rtl/coord_clamp.sv
// Clamps a signed 12-bit predicted coordinate into the frame range [0, MAX].
module coord_clamp
    import tracker_pkg::*;
#(
    parameter int MAX = DEFAULT_WIDTH - 1
) (
    input  vel_t   value,
    output coord_t clamped
);

    localparam vel_t MAX_S = 12'(MAX);

    // Negative sums pin to 0, anything past the frame edge pins to MAX
    always_comb begin
        clamped = value[10:0];
        if (value < 12'sd0) begin
            clamped = '0;
        end else if (value > MAX_S) begin
            clamped = MAX_S[10:0];
        end
    end

endmodule

// File: rtl/blob_tracker.sv
// Single-object blob tracker. Stage 1 registers the extreme points and
// derives found/centre/size; stage 2 runs the SEARCH/ACQUIRE/TRACK/COAST
// FSM, velocity and clamped next-frame prediction.
// Optional build macro BLOB_TRACKER_SMOOTH_EN: in TRACK the reported centre
// is the average of the previous and current centre.
module blob_tracker
    import tracker_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int HEIGHT     = DEFAULT_HEIGHT,
    parameter int LOST_LIMIT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  coord_t [1:0] i_up,
    input  coord_t [1:0] i_left,
    input  coord_t [1:0] i_right,
    input  coord_t [1:0] i_down,
    output logic         o_valid,
    output logic         o_found,
    output logic         o_tracking,
    output coord_t       o_cx,
    output coord_t       o_cy,
    output coord_t       o_bw,
    output coord_t       o_bh,
    output vel_t         o_vx,
    output vel_t         o_vy,
    output coord_t       o_px,
    output coord_t       o_py
);

    localparam logic [3:0] LIMIT = 4'(LOST_LIMIT);

    // Only x of left/right and y of up/down matter for the bounding box
    coord_t      left_x, right_x, up_y, down_y;
    logic [11:0] sum_x, sum_y;
    logic        frame_found;
    logic        unused_bits;

    assign left_x      = i_left[1];
    assign right_x     = i_right[1];
    assign up_y        = i_up[0];
    assign down_y      = i_down[0];
    assign sum_x       = {1'b0, left_x} + {1'b0, right_x};
    assign sum_y       = {1'b0, up_y} + {1'b0, down_y};
    assign frame_found = (left_x != NOT_FOUND) && (up_y != NOT_FOUND) &&
                         (right_x >= left_x) && (down_y >= up_y);

    logic   s1_valid, s1_found;
    coord_t s1_cx, s1_cy, s1_bw, s1_bh;

    // Stage 1: capture detection result, centre and size of the incoming frame
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_found <= 1'b0;
            s1_cx    <= '0;
            s1_cy    <= '0;
            s1_bw    <= '0;
            s1_bh    <= '0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_found <= frame_found;
                s1_cx    <= sum_x[11:1];
                s1_cy    <= sum_y[11:1];
                s1_bw    <= right_x - left_x + 11'd1;
                s1_bh    <= down_y - up_y + 11'd1;
            end
        end
    end

    track_state_t state_q, state_d;
    logic [3:0]   miss_q, miss_d;
    coord_t       prev_cx_q, prev_cy_q, prev_cx_d, prev_cy_d;
    coord_t       use_cx, use_cy;
    logic         found_d, enter_search;
    coord_t       cx_d, cy_d, bw_d, bh_d, base_x, base_y, px_d, py_d;
    vel_t         vx_d, vy_d, step_x, step_y, px_sum, py_sum;

`ifdef BLOB_TRACKER_SMOOTH_EN
    logic [11:0] avg_x, avg_y;
    assign avg_x = {1'b0, prev_cx_q} + {1'b0, s1_cx};
    assign avg_y = {1'b0, prev_cy_q} + {1'b0, s1_cy};

    // A found frame that lands in TRACK reports the averaged centre; ACQUIRE stays raw
    always_comb begin
        use_cx = s1_cx;
        use_cy = s1_cy;
        if (state_q != SEARCH) begin
            use_cx = avg_x[11:1];
            use_cy = avg_y[11:1];
        end
    end
    assign unused_bits = ^{i_left[0], i_right[0], i_up[1], i_down[1],
                           sum_x[0], sum_y[0], avg_x[0], avg_y[0]};
`else
    assign use_cx      = s1_cx;
    assign use_cy      = s1_cy;
    assign unused_bits = ^{i_left[0], i_right[0], i_up[1], i_down[1],
                           sum_x[0], sum_y[0]};
`endif

    // Stage 2: next state, velocity and prediction base for one stage-1 result
    always_comb begin
        state_d      = state_q;
        miss_d       = miss_q;
        found_d      = o_found;
        cx_d         = o_cx;
        cy_d         = o_cy;
        bw_d         = o_bw;
        bh_d         = o_bh;
        vx_d         = o_vx;
        vy_d         = o_vy;
        prev_cx_d    = prev_cx_q;
        prev_cy_d    = prev_cy_q;
        base_x       = o_px;
        base_y       = o_py;
        step_x       = 12'sd0;
        step_y       = 12'sd0;
        enter_search = 1'b0;
        if (s1_valid) begin
            found_d = s1_found;
            if (s1_found) begin
                state_d   = (state_q == SEARCH) ? ACQUIRE : TRACK;
                miss_d    = '0;
                cx_d      = use_cx;
                cy_d      = use_cy;
                bw_d      = s1_bw;
                bh_d      = s1_bh;
                vx_d      = 12'sd0;
                vy_d      = 12'sd0;
                if (state_q != SEARCH) begin
                    vx_d = $signed({1'b0, use_cx}) - $signed({1'b0, prev_cx_q});
                    vy_d = $signed({1'b0, use_cy}) - $signed({1'b0, prev_cy_q});
                end
                prev_cx_d = use_cx;
                prev_cy_d = use_cy;
                base_x    = use_cx;
                base_y    = use_cy;
                step_x    = vx_d;
                step_y    = vy_d;
            end else begin
                case (state_q)
                    SEARCH:  ;
                    ACQUIRE: enter_search = 1'b1;
                    TRACK: begin
                        miss_d = 4'd1;
                        if (miss_d == LIMIT) begin
                            enter_search = 1'b1;
                        end else begin
                            state_d = COAST;
                        end
                    end
                    COAST: begin
                        miss_d = miss_q + 4'd1;
                        if (miss_d == LIMIT) begin
                            enter_search = 1'b1;
                        end
                    end
                endcase
                if (enter_search) begin
                    state_d = SEARCH;
                    miss_d  = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                    bw_d    = '0;
                    bh_d    = '0;
                    vx_d    = 12'sd0;
                    vy_d    = 12'sd0;
                end else if (state_d == COAST) begin
                    step_x = o_vx;
                    step_y = o_vy;
                end
            end
        end
    end

    assign px_sum = sat_add(base_x, step_x);
    assign py_sum = sat_add(base_y, step_y);

    coord_clamp #(.MAX(WIDTH - 1))  u_clamp_x (.value(px_sum), .clamped(px_d));
    coord_clamp #(.MAX(HEIGHT - 1)) u_clamp_y (.value(py_sum), .clamped(py_d));

    // Stage 2 register: state and outputs move only when a stage-1 result arrives
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= SEARCH;
            miss_q    <= '0;
            prev_cx_q <= '0;
            prev_cy_q <= '0;
            o_valid   <= 1'b0;
            o_found   <= 1'b0;
            o_cx      <= '0;
            o_cy      <= '0;
            o_bw      <= '0;
            o_bh      <= '0;
            o_vx      <= '0;
            o_vy      <= '0;
            o_px      <= '0;
            o_py      <= '0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                state_q   <= state_d;
                miss_q    <= miss_d;
                prev_cx_q <= prev_cx_d;
                prev_cy_q <= prev_cy_d;
                o_found   <= found_d;
                o_cx      <= cx_d;
                o_cy      <= cy_d;
                o_bw      <= bw_d;
                o_bh      <= bh_d;
                o_vx      <= vx_d;
                o_vy      <= vy_d;
                o_px      <= px_d;
                o_py      <= py_d;
            end
        end
    end

    assign o_tracking = (state_q != SEARCH);

endmodule

// File: tb/tb_blob_tracker.sv
// Testbench for blob_tracker: directed scenarios plus a randomized run,
// all checked against a frame-level behavioural model of the tracker.
module tb_blob_tracker;

    localparam int W    = 640;
    localparam int H    = 480;
    localparam int LOST = 4;

    logic              i_clk = 1'b0;
    logic              i_rst, i_valid;
    logic [1:0][10:0]  i_up, i_left, i_right, i_down;
    logic              o_valid, o_found, o_tracking;
    logic [10:0]       o_cx, o_cy, o_bw, o_bh, o_px, o_py;
    logic signed [11:0] o_vx, o_vy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model of the track: whether an object is held, whether it has been
    // seen twice, consecutive misses, last seen centre and reported values
    int m_has, m_conf, m_miss, m_found;
    int m_cx, m_cy, m_bw, m_bh, m_vx, m_vy, m_px, m_py, m_lx, m_ly;
    int walk_x, walk_y;
    int f_lx[3], f_rx[3], f_uy[3], f_dy[3];

    blob_tracker #(.WIDTH(W), .HEIGHT(H), .LOST_LIMIT(LOST)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_up(i_up), .i_left(i_left), .i_right(i_right), .i_down(i_down),
        .o_valid(o_valid), .o_found(o_found), .o_tracking(o_tracking),
        .o_cx(o_cx), .o_cy(o_cy), .o_bw(o_bw), .o_bh(o_bh),
        .o_vx(o_vx), .o_vy(o_vy), .o_px(o_px), .o_py(o_py)
    );

    always #5 i_clk = ~i_clk;

    function automatic int clip(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_drop();
        m_has = 0; m_conf = 0; m_miss = 0;
        m_cx = 0; m_cy = 0; m_bw = 0; m_bh = 0; m_vx = 0; m_vy = 0;
    endtask

    task automatic model_reset();
        model_drop();
        m_found = 0; m_px = 0; m_py = 0; m_lx = 0; m_ly = 0;
    endtask

    task automatic model_frame(input int lx, input int rx, input int uy, input int dy);
        int cx, cy;
        m_found = (lx != 2023 && uy != 2023 && rx >= lx && dy >= uy) ? 1 : 0;
        if (m_found == 1) begin
            cx = (lx + rx) / 2;
            cy = (uy + dy) / 2;
            if (m_has == 1) begin
                m_vx = cx - m_lx; m_vy = cy - m_ly; m_conf = 1;
            end else begin
                m_vx = 0; m_vy = 0; m_has = 1; m_conf = 0;
            end
            m_miss = 0; m_lx = cx; m_ly = cy;
            m_cx = cx; m_cy = cy; m_bw = rx - lx + 1; m_bh = dy - uy + 1;
            m_px = clip(cx + m_vx, W - 1);
            m_py = clip(cy + m_vy, H - 1);
        end else if (m_has == 1) begin
            if (m_conf == 0) begin
                model_drop();
            end else begin
                m_miss++;
                if (m_miss >= LOST) begin
                    model_drop();
                end else begin
                    m_px = clip(m_px + m_vx, W - 1);
                    m_py = clip(m_py + m_vy, H - 1);
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input int exp_valid);
        check({tag, ".valid"}, o_valid, exp_valid);
        check({tag, ".found"}, o_found, m_found);
        check({tag, ".tracking"}, o_tracking, m_has);
        check({tag, ".cx"}, o_cx, m_cx);
        check({tag, ".cy"}, o_cy, m_cy);
        check({tag, ".bw"}, o_bw, m_bw);
        check({tag, ".bh"}, o_bh, m_bh);
        check({tag, ".vx"}, o_vx, m_vx);
        check({tag, ".vy"}, o_vy, m_vy);
        check({tag, ".px"}, o_px, m_px);
        check({tag, ".py"}, o_py, m_py);
    endtask

    // Drives one frame; coordinates the tracker ignores get random filler
    task automatic drive(input int lx, input int rx, input int uy, input int dy);
        i_left[1]  = 11'(lx);  i_left[0]  = 11'($urandom_range(0, 2047));
        i_right[1] = 11'(rx);  i_right[0] = 11'($urandom_range(0, 2047));
        i_up[0]    = 11'(uy);  i_up[1]    = 11'($urandom_range(0, 2047));
        i_down[0]  = 11'(dy);  i_down[1]  = 11'($urandom_range(0, 2047));
        i_valid    = 1'b1;
    endtask

    task automatic apply_stimulus(input string tag, input int lx, input int rx, input int uy, input int dy);
        @(negedge i_clk);
        drive(lx, rx, uy, dy);
        @(negedge i_clk);
        i_valid = 1'b0;
        check({tag, ".early"}, o_valid, 0);
        @(negedge i_clk);
        model_frame(lx, rx, uy, dy);
        check_output(tag, 1);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int r, w, h, lx, rx, uy, dy, gap;
        i_rst = 1'b1; i_valid = 1'b0;
        i_up = '0; i_left = '0; i_right = '0; i_down = '0;
        model_reset();

        do_reset();
        check_output("reset", 0);

        // First detection enters ACQUIRE with zero velocity
        apply_stimulus("acq", 100, 140, 180, 230);
        check("acq.cx_c", o_cx, 120);
        check("acq.cy_c", o_cy, 205);
        check("acq.bw_c", o_bw, 41);
        check("acq.bh_c", o_bh, 51);
        check("acq.vx_c", o_vx, 0);

        // Shift by +10 in x moves to TRACK
        apply_stimulus("trk", 110, 150, 180, 230);
        check("trk.cx_c", o_cx, 130);
        check("trk.vx_c", o_vx, 10);
        check("trk.px_c", o_px, 140);

        // Prediction clamps at both frame edges
        apply_stimulus("clamp0", 600, 620, 180, 230);
        apply_stimulus("clamp1", 620, 640, 180, 230);
        check("clamp1.px_c", o_px, 639);
        apply_stimulus("clamp2", 1320, 1340, 180, 230);
        apply_stimulus("clamp3", 620, 640, 180, 230);
        check("clamp3.vx_c", o_vx, -700);
        check("clamp3.px_c", o_px, 0);

        // Four misses: three COAST results with dead reckoning, then SEARCH
        apply_stimulus("coast_a", 90, 110, 180, 230);
        apply_stimulus("coast_b", 95, 115, 180, 230);
        for (int k = 1; k <= 4; k++) begin
            apply_stimulus($sformatf("miss%0d", k), 2023, 50, 180, 230);
        end
        check("miss4.tracking_c", o_tracking, 0);
        check("miss4.vx_c", o_vx, 0);

        // Reacquire, miss twice, then recover into TRACK
        apply_stimulus("rec_a", 190, 210, 180, 230);
        apply_stimulus("rec_b", 200, 220, 180, 230);
        apply_stimulus("rec_m1", 2023, 0, 180, 230);
        apply_stimulus("rec_m2", 2023, 0, 180, 230);
        check("rec_m2.px_c", o_px, 240);
        apply_stimulus("rec_c", 220, 240, 180, 230);
        check("rec_c.vx_c", o_vx, 20);
        check("rec_c.tracking_c", o_tracking, 1);

        // Inverted box is not found and SEARCH is unchanged
        do_reset();
        apply_stimulus("inv", 300, 200, 180, 230);
        check("inv.found_c", o_found, 0);
        check("inv.tracking_c", o_tracking, 0);

        // Three back-to-back frames give three consecutive results
        f_lx = '{100, 110, 120}; f_rx = '{120, 130, 140};
        f_uy = '{50, 52, 54};    f_dy = '{60, 62, 64};
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clk);
            if (c < 3) drive(f_lx[c], f_rx[c], f_uy[c], f_dy[c]);
            else i_valid = 1'b0;
            if (c == 1) check("b2b.early", o_valid, 0);
            if (c >= 2 && c <= 4) begin
                model_frame(f_lx[c-2], f_rx[c-2], f_uy[c-2], f_dy[c-2]);
                check_output($sformatf("b2b%0d", c - 2), 1);
            end
            if (c == 5) check("b2b.after", o_valid, 0);
        end

        // Reset during a burst discards everything in flight
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            i_rst = (c == 1 || c == 2) ? 1'b1 : 1'b0;
            if (c < 3) drive(f_lx[c], f_rx[c], f_uy[c], f_dy[c]);
            else i_valid = 1'b0;
            if (c >= 2) check($sformatf("rstb.valid%0d", c), o_valid, 0);
        end
        model_reset();
        check_output("rstb", 0);

        // Randomized frames on a random walk, with holds checked in the gaps
        walk_x = 300; walk_y = 200;
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                walk_x = int'($urandom_range(0, 1900));
                walk_y = int'($urandom_range(0, 1900));
            end
            walk_x = clip(walk_x + int'($urandom_range(0, 60)) - 30, 1900);
            walk_y = clip(walk_y + int'($urandom_range(0, 60)) - 30, 1900);
            w = int'($urandom_range(0, 60));
            h = int'($urandom_range(0, 60));
            lx = walk_x; rx = walk_x + w; uy = walk_y; dy = walk_y + h;
            if (r >= 70 && r < 80) lx = 2023;
            else if (r >= 80 && r < 87) uy = 2023;
            else if (r >= 87 && r < 93) begin rx = walk_x; lx = walk_x + w + 1; end
            else if (r >= 93 && r < 97) begin dy = walk_y; uy = walk_y + h + 1; end
            apply_stimulus($sformatf("rnd%0d", n), lx, rx, uy, dy);
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                repeat (gap) @(negedge i_clk);
                check_output($sformatf("hold%0d", n), 0);
            end
        end

        $display("[TB] directed and random sequences complete");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
